// File: rtl/column_select_if.sv
`default_nettype none
// ============================================================================
//  Module      : column_select_if
//  Description : Drop-request handshake between the player-input controller
//                (master) and the board logic (slave). The master raises
//                drop_valid with a stable drop_col/drop_player until the board
//                accepts with drop_ready; the board later pulses place_done
//                once the piece has landed.
//  Revision    : 1.0 - initial release
// ============================================================================
interface column_select_if #(
    parameter int COL_W = 3
);
    logic             drop_valid;
    logic             drop_ready;
    logic [COL_W-1:0] drop_col;
    logic             drop_player;
    logic             place_done;

    // Controller side: owns the request, observes acceptance and completion.
    modport master (
        output drop_valid,
        output drop_col,
        output drop_player,
        input  drop_ready,
        input  place_done
    );

    // Board side: consumes the request, reports acceptance and completion.
    modport slave (
        input  drop_valid,
        input  drop_col,
        input  drop_player,
        output drop_ready,
        output place_done
    );
endinterface
`default_nettype wire

// File: rtl/column_select.sv
`default_nettype none
// ============================================================================
//  Module      : column_select
//  Description : Connect-4 player-input controller. Consumes debounced
//                one-cycle left/right/drop pulses, keeps the cursor column and
//                the active player, and issues a registered drop request to
//                the board over a valid/ready handshake. The active player
//                flips when the board reports the piece placed.
//
//                Configuration macro:
//                  CURSOR_WRAP_EN - defined  : cursor wraps at both edges
//                                   undefined: cursor saturates at the edges
//
//                Reset (rst) is asynchronous and active-low; all outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module column_select #(
    parameter int COLUMNS = 7,
    parameter int COL_W   = 3
) (
    input  logic                clk,
    input  logic                rst,           // active-low, asynchronous assert
    input  logic                left_pulse_i,
    input  logic                right_pulse_i,
    input  logic                drop_pulse_i,
    input  logic                new_game_i,
    input  logic                game_over_i,
    input  logic [COLUMNS-1:0]  col_full_i,
    column_select_if.master     drop_if,
    output logic [COL_W-1:0]    cursor_o,
    output logic                player_o,
    output logic                reject_o,
    output logic                busy_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Home column used after reset and on a soft restart.
    localparam logic [COL_W-1:0] c_home = COL_W'(COLUMNS / 2);
    // Right-most legal column index.
    localparam logic [COL_W-1:0] c_last = COL_W'(COLUMNS - 1);
    localparam logic [COL_W-1:0] c_zero = '0;
    localparam logic [COL_W-1:0] c_one  = COL_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    // IDLE : accepting button input
    // REQ  : drop request presented, waiting for the board to accept
    // WAIT : request accepted, waiting for the board to finish placing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [COL_W-1:0] cursor_q;
    logic [COL_W-1:0] cursor_d;
    logic             player_q;
    logic             drop_valid_q;
    logic [COL_W-1:0] drop_col_q;
    logic             drop_player_q;
    logic             reject_q;
    logic             busy_q;

    // A simultaneous left+right press cancels out rather than picking one.
    logic w_move_left;
    logic w_move_right;
    logic w_col_full;

    assign w_move_left  = left_pulse_i  & ~right_pulse_i;
    assign w_move_right = right_pulse_i & ~left_pulse_i;

    // The cursor never leaves [0, COLUMNS-1], so this index is always in range.
    assign w_col_full   = col_full_i[cursor_q];

    // Next cursor position for a move press; edge handling depends on build.
    always_comb begin
        cursor_d = cursor_q;
        if (w_move_left) begin
            if (cursor_q == c_zero) begin
`ifdef CURSOR_WRAP_EN
                cursor_d = c_last;
`else
                cursor_d = cursor_q;
`endif
            end else begin
                cursor_d = cursor_q - c_one;
            end
        end else if (w_move_right) begin
            if (cursor_q == c_last) begin
`ifdef CURSOR_WRAP_EN
                cursor_d = c_zero;
`else
                cursor_d = cursor_q;
`endif
            end else begin
                cursor_d = cursor_q + c_one;
            end
        end
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cursor_q      <= c_home;
            player_q      <= 1'b0;
            drop_valid_q  <= 1'b0;
            drop_col_q    <= c_zero;
            drop_player_q <= 1'b0;
            reject_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else if (new_game_i) begin
            // Soft restart overrides everything, including a live handshake.
            // drop_col/drop_player are left as-is: they are only meaningful
            // while drop_valid is high.
            state_q      <= ST_IDLE;
            cursor_q     <= c_home;
            player_q     <= 1'b0;
            drop_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // reject is a single-cycle pulse unless re-raised below.
            reject_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A finished game freezes input, without raising reject.
                    if (!game_over_i) begin
                        if (drop_pulse_i) begin
                            // Drop wins over any move in the same cycle and
                            // uses the cursor as it stands now.
                            if (w_col_full) begin
                                reject_q <= 1'b1;
                            end else begin
                                drop_col_q    <= cursor_q;
                                drop_player_q <= player_q;
                                drop_valid_q  <= 1'b1;
                                busy_q        <= 1'b1;
                                state_q       <= ST_REQ;
                            end
                        end else begin
                            cursor_q <= cursor_d;
                        end
                    end
                end

                ST_REQ: begin
                    // Request is held until the board takes it; button input
                    // and game_over have no effect here.
                    if (drop_if.drop_ready) begin
                        drop_valid_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Turn passes to the other player once the piece lands.
                    if (drop_if.place_done) begin
                        player_q <= ~player_q;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    state_q      <= ST_IDLE;
                    drop_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping (all straight from registers)
    // ------------------------------------------------------------------------
    assign cursor_o            = cursor_q;
    assign player_o            = player_q;
    assign reject_o            = reject_q;
    assign busy_o              = busy_q;
    assign drop_if.drop_valid  = drop_valid_q;
    assign drop_if.drop_col    = drop_col_q;
    assign drop_if.drop_player = drop_player_q;

endmodule
`default_nettype wire

// File: tb/tb_column_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_column_select
//  Description : Self-checking bench for column_select. A turn-level model of
//                the controller (cursor, whose turn, request outstanding,
//                piece being placed) predicts every output; directed scenarios
//                cover the documented cases and a randomized run covers the
//                rest. Honours CURSOR_WRAP_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_column_select;

    localparam int COLUMNS = 7;
    localparam int COL_W   = 3;
    localparam int OBS_W   = 2 * COL_W + 5;

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               left_pulse;
    logic               right_pulse;
    logic               drop_pulse;
    logic               new_game;
    logic               game_over;
    logic [COLUMNS-1:0] col_full;
    logic [COL_W-1:0]   cursor;
    logic               player;
    logic               reject;
    logic               busy;

    column_select_if #(.COL_W(COL_W)) bus ();

    column_select #(
        .COLUMNS (COLUMNS),
        .COL_W   (COL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .left_pulse_i  (left_pulse),
        .right_pulse_i (right_pulse),
        .drop_pulse_i  (drop_pulse),
        .new_game_i    (new_game),
        .game_over_i   (game_over),
        .col_full_i    (col_full),
        .drop_if       (bus.master),
        .cursor_o      (cursor),
        .player_o      (player),
        .reject_o      (reject),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- turn-level reference model ----------------
    int m_cursor;
    int m_player;
    int m_col;
    int m_dplayer;
    bit m_requesting;   // a piece is offered to the board
    bit m_placing;      // board took the piece and is placing it
    bit m_reject;

    task automatic model_reset();
        m_cursor     = COLUMNS / 2;
        m_player     = 0;
        m_col        = 0;
        m_dplayer    = 0;
        m_requesting = 1'b0;
        m_placing    = 1'b0;
        m_reject     = 1'b0;
    endtask

    function automatic logic [OBS_W-1:0] exp_vec();
        return {COL_W'(m_cursor), m_player[0], m_requesting, COL_W'(m_col),
                m_dplayer[0], m_reject, (m_requesting | m_placing)};
    endfunction

    function automatic logic [OBS_W-1:0] obs_vec();
        return {cursor, player, bus.drop_valid, bus.drop_col,
                bus.drop_player, reject, busy};
    endfunction

    // Advance one clock: predict from the inputs present at the edge, then
    // sample 1 ns after it and clear the one-cycle pulses.
    task automatic tick();
        if (new_game) begin
            m_cursor     = COLUMNS / 2;
            m_player     = 0;
            m_requesting = 1'b0;
            m_placing    = 1'b0;
            m_reject     = 1'b0;
        end else begin
            m_reject = 1'b0;
            if (m_requesting) begin
                if (bus.drop_ready) begin
                    m_requesting = 1'b0;
                    m_placing    = 1'b1;
                end
            end else if (m_placing) begin
                if (bus.place_done) begin
                    m_placing = 1'b0;
                    m_player  = 1 - m_player;
                end
            end else if (!game_over) begin
                if (drop_pulse) begin
                    if (col_full[m_cursor]) begin
                        m_reject = 1'b1;
                    end else begin
                        m_col        = m_cursor;
                        m_dplayer    = m_player;
                        m_requesting = 1'b1;
                    end
                end else if (left_pulse && !right_pulse) begin
                    if (WRAP) m_cursor = (m_cursor + COLUMNS - 1) % COLUMNS;
                    else      m_cursor = (m_cursor > 0) ? m_cursor - 1 : 0;
                end else if (right_pulse && !left_pulse) begin
                    if (WRAP) m_cursor = (m_cursor + 1) % COLUMNS;
                    else      m_cursor = (m_cursor < COLUMNS - 1) ? m_cursor + 1 : m_cursor;
                end
            end
        end
        @(posedge clk);
        #1;
        left_pulse     = 1'b0;
        right_pulse    = 1'b0;
        drop_pulse     = 1'b0;
        bus.place_done = 1'b0;
    endtask

    // Walk the cursor to column c (bounded).
    task automatic goto_col(input int c);
        for (int i = 0; i < 2 * COLUMNS && m_cursor != c; i++) begin
            if (m_cursor < c) right_pulse = 1'b1;
            else              left_pulse  = 1'b1;
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        #11;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec(), exp_vec());
        end
        vectors++;
        if (cursor !== COL_W'(COLUMNS / 2)) begin
            miscompares++;
            $display("FAIL reset_cursor: got %0d want %0d", cursor, COLUMNS / 2);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_cursor_move();
        for (int i = 0; i < 3; i++) begin
            right_pulse = 1'b1;
            tick();
            vectors++;
            if (cursor !== COL_W'(4 + i) || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL move_right_%0d: got cursor %0d want %0d", i, cursor, 4 + i);
            end
        end
        right_pulse = 1'b1;
        tick();
        vectors++;
        if (cursor !== COL_W'(WRAP ? 0 : COLUMNS - 1) || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL right_edge: got cursor %0d want %0d", cursor, m_cursor);
        end
        goto_col(0);
        left_pulse = 1'b1;
        tick();
        vectors++;
        if (cursor !== COL_W'(WRAP ? COLUMNS - 1 : 0) || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL left_edge: got cursor %0d want %0d", cursor, m_cursor);
        end
    endtask

    task automatic test_drop_handshake();
        int cycles;
        goto_col(2);
        col_full       = '0;
        bus.drop_ready = 1'b0;
        drop_pulse     = 1'b1;
        tick();
        cycles = 0;
        for (int i = 0; i < 20 && bus.drop_valid === 1'b1; i++) begin
            cycles++;
            vectors++;
            if (bus.drop_col !== 3'd2 || bus.drop_player !== 1'b0 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL req_hold_%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (cycles == 5) bus.drop_ready = 1'b1;
            tick();
        end
        bus.drop_ready = 1'b0;
        vectors++;
        if (cycles != 5) begin
            miscompares++;
            $display("FAIL req_duration: got %0d cycles want 5", cycles);
        end
        repeat (3) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL wait_busy: got %b want %b", obs_vec(), exp_vec());
            end
        end
        bus.place_done = 1'b1;
        tick();
        vectors++;
        if (player !== 1'b1 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL place_done: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reject();
        goto_col(3);
        col_full   = 7'b0001000;
        drop_pulse = 1'b1;
        tick();
        vectors++;
        if (reject !== 1'b1 || bus.drop_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reject_pulse: got %b want %b", obs_vec(), exp_vec());
        end
        tick();
        vectors++;
        if (reject !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reject_single: got %b want %b", obs_vec(), exp_vec());
        end
        col_full = '0;
    endtask

    task automatic test_simultaneous();
        left_pulse  = 1'b1;
        right_pulse = 1'b1;
        tick();
        vectors++;
        if (cursor !== 3'd3 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL left_right_same: got %b want %b", obs_vec(), exp_vec());
        end
        goto_col(4);
        drop_pulse = 1'b1;
        left_pulse = 1'b1;
        tick();
        vectors++;
        if (cursor !== 3'd4 || bus.drop_col !== 3'd4 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL drop_over_move: got %b want %b", obs_vec(), exp_vec());
        end
        bus.drop_ready = 1'b1;
        tick();
        bus.drop_ready = 1'b0;
        bus.place_done = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL drop_over_move_done: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ignore();
        drop_pulse     = 1'b1;
        tick();
        bus.drop_ready = 1'b1;
        tick();
        bus.drop_ready = 1'b0;
        left_pulse     = 1'b1;
        drop_pulse     = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL wait_ignores_buttons: got %b want %b", obs_vec(), exp_vec());
        end
        bus.place_done = 1'b1;
        tick();
        game_over  = 1'b1;
        drop_pulse = 1'b1;
        col_full   = '1;
        tick();
        vectors++;
        if (reject !== 1'b0 || bus.drop_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL game_over_drop: got %b want %b", obs_vec(), exp_vec());
        end
        right_pulse = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL game_over_move: got %b want %b", obs_vec(), exp_vec());
        end
        game_over = 1'b0;
        col_full  = '0;
    endtask

    task automatic test_new_game();
        goto_col(5);
        drop_pulse = 1'b1;
        tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        vectors++;
        if (bus.drop_valid !== 1'b0 || cursor !== 3'd3 || player !== 1'b0 || busy !== 1'b0
            || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL new_game_in_req: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        goto_col(1);
        drop_pulse = 1'b1;
        tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (bus.drop_valid !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_reset_release: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            left_pulse     = ($urandom_range(0, 3) == 0);
            right_pulse    = ($urandom_range(0, 3) == 0);
            drop_pulse     = ($urandom_range(0, 3) == 0);
            new_game       = ($urandom_range(0, 63) == 0);
            game_over      = ($urandom_range(0, 15) == 0);
            bus.drop_ready = $urandom_range(0, 1) == 1;
            bus.place_done = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < COLUMNS; b++) col_full[b] = ($urandom_range(0, 5) == 0);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        new_game       = 1'b0;
        game_over      = 1'b0;
        bus.drop_ready = 1'b0;
        col_full       = '0;
    endtask

    initial begin
        left_pulse     = 1'b0;
        right_pulse    = 1'b0;
        drop_pulse     = 1'b0;
        new_game       = 1'b0;
        game_over      = 1'b0;
        col_full       = '0;
        bus.drop_ready = 1'b0;
        bus.place_done = 1'b0;
        model_reset();

        test_reset();
        test_cursor_move();
        test_drop_handshake();
        test_reject();
        test_simultaneous();
        test_ignore();
        test_new_game();
        test_async_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/column_select.md
# column_select

Player-input controller sitting directly downstream of the per-button debounce stages in the Connect-4 design. Consumes single-cycle press pulses for left, right and drop. Maintains the cursor column and the current player, and issues a registered drop request to the board logic over a valid/ready handshake. Flips the active player once the board reports the piece placed.

## Interface
- COLUMNS, 7: number of board columns (≥2).
- COL_W, 3: cursor/column index width; must satisfy 2^COL_W ≥ COLUMNS.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- left_pulse  in  1  one-cycle press pulse from debounce: move cursor left.
- right_pulse  in  1  one-cycle press pulse: move cursor right.
- drop_pulse  in  1  one-cycle press pulse: drop piece in cursor column.
- new_game  in  1  synchronous soft restart (level, sampled every cycle).
- game_over  in  1  board reports game finished; blocks moves and drops.
- col_full  in  COLUMNS  bit i = 1 when column i is full.
- drop_ready  in  1  board can accept a drop request this cycle.
- place_done  in  1  one-cycle pulse: board finished placing the piece.
- cursor  out  COL_W  current cursor column.
- player  out  1  active player (0 = P1, 1 = P2).
- drop_valid  out  1  drop request pending.
- drop_col  out  COL_W  requested column; stable while drop_valid.
- drop_player  out  1  player owning the request; stable while drop_valid.
- reject  out  1  one-cycle pulse: drop refused (column full).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE:
  - left/right move the cursor.
  - drop_pulse with col_full[cursor]=0 → latch drop_col=cursor and drop_player=player, then go to REQ.
  - drop_pulse with col_full[cursor]=1 → reject pulse, remain IDLE.
- REQ:
  - drop_valid=1.
  - On a clock edge with drop_valid & drop_ready: go to WAIT; drop_valid deasserts the next cycle.
  - drop_valid is never withdrawn without acceptance, except by new_game or reset.
- WAIT: place_done → player toggles, go to IDLE.
- Outside IDLE, all button pulses are ignored and dropped, not queued. place_done outside WAIT is ignored.
- Priority in IDLE: drop_pulse > left/right. If drop and a move arrive in the same cycle, the drop uses the current cursor and the cursor does not move.
- left_pulse and right_pulse in the same cycle: no movement.
- game_over=1 in IDLE: moves and drops ignored, no reject. game_over in REQ/WAIT does not abort the handshake.
- Cursor arithmetic is unsigned in COL_W bits; values ≥COLUMNS never occur.
- Edge behaviour (left at 0, right at COLUMNS-1) is set by the configuration macro below.
- new_game=1 (highest priority, any state): cursor=COLUMNS/2 (integer division), player=0, state=IDLE, drop_valid=0, reject=0.

## Timing
- Reset values:
  - cursor=COLUMNS/2 (3 at default).
  - player=0, drop_valid=0, drop_col=0, drop_player=0, reject=0, busy=0.
  - state=IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Move pulse at edge N → new cursor visible after edge N (one-cycle latency).
- drop_pulse at edge N → drop_valid, drop_col, drop_player and busy high after N.
- reject high for exactly one cycle after the offending edge.
- Handshake accepted at edge M → drop_valid=0 after M; the minimum request duration is one cycle.
- place_done at edge P (in WAIT) → player toggled, busy=0 after P. The next drop is accepted from edge P+1.
- Reset assertion mid-handshake clears everything immediately (asynchronous); deassertion is synchronous to clk at the source.

## Configuration
- CURSOR_WRAP_EN defined:
  - left at column 0 → COLUMNS-1.
  - right at COLUMNS-1 → 0.
- Not defined: the cursor saturates; left at 0 and right at COLUMNS-1 leave the cursor unchanged.
- All other behaviour is identical in both builds.

## Test plan
- Reset release, then right_pulse ×3 → cursor 3→4→5→6. Another right → 6 (saturate build) or 0 (CURSOR_WRAP_EN build).
- Cursor 2, col_full=0, drop_pulse, drop_ready held 0 for 4 cycles then 1 → drop_valid high 5 cycles with drop_col=2, drop_player=0. busy stays high until place_done, then player=1.
- col_full[3]=1, cursor 3, drop_pulse → reject high exactly 1 cycle, drop_valid stays 0, state IDLE.
- left_pulse+right_pulse same cycle → cursor unchanged. drop_pulse+left_pulse same cycle at cursor 4 → drop_col=4, cursor stays 4.
- In WAIT: left_pulse and drop_pulse ignored. game_over=1 in IDLE: drop_pulse gives no request and no reject.
- new_game asserted during REQ → drop_valid=0, cursor=3, player=0, busy=0 next cycle.
- Async rst low mid-REQ → all outputs at reset values immediately.
